// File: rtl/diff_sample_sequencer_if.sv
// diff_sample_sequencer_if
//   Differentiator-side stream signals of the sample sequencer.
//   master : the sequencer (drives the sample stream, receives results)
//   slave  : the differentiator (accepts samples, returns results)
//   s_axis_tvalid/s_axis_tready/s_axis_tdata : sample stream to the differentiator
//   m_axis_tvalid/m_axis_tdata               : result stream from the differentiator
interface diff_sample_sequencer_if #(
    parameter int unsigned DATA_W = 16
);
    logic              s_axis_tvalid;
    logic              s_axis_tready;
    logic [DATA_W-1:0] s_axis_tdata;
    logic              m_axis_tvalid;
    logic [DATA_W-1:0] m_axis_tdata;

    modport master (
        output s_axis_tvalid,
        output s_axis_tdata,
        input  s_axis_tready,
        input  m_axis_tvalid,
        input  m_axis_tdata
    );

    modport slave (
        input  s_axis_tvalid,
        input  s_axis_tdata,
        output s_axis_tready,
        output m_axis_tvalid,
        output m_axis_tdata
    );
endinterface

// File: rtl/diff_sample_sequencer.sv
// diff_sample_sequencer
//   Paces the latest ADC sample into the FIR differentiator at a fixed rate, one
//   transaction in flight, drops the start-up transient results and forwards the rest.
//   clk, rst          : clock, synchronous active-high reset
//   enable            : run/stop (acted on only while waiting for a tick)
//   clear_err         : pulse clearing the sticky error bits (a same-cycle set wins)
//   adc_valid/adc_data: ADC sample input, captured into a holding register
//   axis              : differentiator sample stream (out) and result stream (in)
//   out_valid/out_data: one-cycle forwarded derivative
//   busy              : transaction in flight (SEND or WAIT_RES)
//   err_timeout       : sticky, no result within TIMEOUT cycles
//   err_overrun       : sticky, tick arrived while a transaction was in flight
//   sample_count      : results forwarded, wraps at 2^32
module diff_sample_sequencer #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned TICK_DIV = 250000,
    parameter int unsigned TIMEOUT  = 64,
    parameter int unsigned DISCARD  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    clear_err,
    input  logic                    adc_valid,
    input  logic [DATA_W-1:0]       adc_data,
    diff_sample_sequencer_if.master axis,
    output logic                    out_valid,
    output logic [DATA_W-1:0]       out_data,
    output logic                    busy,
    output logic                    err_timeout,
    output logic                    err_overrun,
    output logic [31:0]             sample_count
);
    localparam int unsigned TickW = $clog2(TICK_DIV);
    localparam int unsigned ToW   = $clog2(TIMEOUT);
    localparam int unsigned DiscW = (DISCARD > 0) ? $clog2(DISCARD + 1) : 1;

    localparam logic [TickW-1:0] TickLast = TickW'(TICK_DIV - 1);
    localparam logic [ToW-1:0]   ToLast   = ToW'(TIMEOUT - 1);
    localparam logic [DiscW-1:0] DiscInit = DiscW'(DISCARD);

    typedef enum logic [1:0] {StIdle, StWaitTick, StSend, StWaitRes} state_e;

    state_e             state_q, state_d;
    logic [TickW-1:0]   tick_cnt_q, tick_cnt_d;
    logic [DATA_W-1:0]  hold_q, hold_d;
    logic [DATA_W-1:0]  tdata_q, tdata_d;
    logic [ToW-1:0]     to_cnt_q, to_cnt_d;
    logic [DiscW-1:0]   disc_q, disc_d;
    logic               out_valid_q, out_valid_d;
    logic [DATA_W-1:0]  out_data_q, out_data_d;
    logic [31:0]        count_q, count_d;
    logic               err_to_q, err_to_d;
    logic               err_ov_q, err_ov_d;

    logic tick;
    logic in_flight;
    logic res_take;
    logic timeout_hit;

    // The tick counter starts one cycle after the enable rise (IDLE -> WAIT_TICK) so
    // the first tick lands TICK_DIV cycles after the FSM leaves IDLE.
    assign tick        = enable && (state_q != StIdle) && (tick_cnt_q == TickLast);
    assign in_flight   = (state_q == StSend) || (state_q == StWaitRes);
    assign res_take    = (state_q == StWaitRes) && axis.m_axis_tvalid;
    assign timeout_hit = (state_q == StWaitRes) && !axis.m_axis_tvalid && (to_cnt_q == ToLast);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (enable) state_d = StWaitTick;
            end
            StWaitTick: begin
                if (!enable)   state_d = StIdle;
                else if (tick) state_d = StSend;
            end
            StSend: begin
                if (axis.s_axis_tready) state_d = StWaitRes;
            end
            StWaitRes: begin
                if (res_take || timeout_hit) state_d = StWaitTick;
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs
    always_comb begin
        axis.s_axis_tvalid = (state_q == StSend);
        axis.s_axis_tdata  = tdata_q;
        busy               = in_flight;
    end

    // Datapath next-state
    always_comb begin
        tick_cnt_d = '0;
        if (enable && (state_q != StIdle)) begin
            tick_cnt_d = (tick_cnt_q == TickLast) ? '0 : tick_cnt_q + TickW'(1);
        end

        hold_d = adc_valid ? adc_data : hold_q;

        // Sample is frozen from the tick until the handshake completes.
        tdata_d = tdata_q;
        if ((state_q == StWaitTick) && tick) tdata_d = hold_q;

        to_cnt_d = to_cnt_q;
        if (state_q == StSend)         to_cnt_d = '0;
        else if (state_q == StWaitRes) to_cnt_d = to_cnt_q + ToW'(1);

        disc_d = disc_q;
        if ((state_q == StIdle) && enable)        disc_d = DiscInit;
        else if (res_take && (disc_q != '0))      disc_d = disc_q - DiscW'(1);

        out_valid_d = res_take && (disc_q == '0);
        out_data_d  = out_valid_d ? axis.m_axis_tdata : out_data_q;
        count_d     = count_q + 32'(out_valid_d);

        // Clear first so a simultaneous set takes priority.
        err_to_d = clear_err ? 1'b0 : err_to_q;
        if (timeout_hit) err_to_d = 1'b1;
        err_ov_d = clear_err ? 1'b0 : err_ov_q;
        if (tick && in_flight) err_ov_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt_q  <= '0;
            hold_q      <= '0;
            tdata_q     <= '0;
            to_cnt_q    <= '0;
            disc_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            count_q     <= '0;
            err_to_q    <= 1'b0;
            err_ov_q    <= 1'b0;
        end else begin
            tick_cnt_q  <= tick_cnt_d;
            hold_q      <= hold_d;
            tdata_q     <= tdata_d;
            to_cnt_q    <= to_cnt_d;
            disc_q      <= disc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            count_q     <= count_d;
            err_to_q    <= err_to_d;
            err_ov_q    <= err_ov_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign sample_count = count_q;
    assign err_timeout  = err_to_q;
    assign err_overrun  = err_ov_q;
endmodule

// File: tb/tb_diff_sample_sequencer.sv
// tb_diff_sample_sequencer
//   Directed bench. dut_a (TICK_DIV=8, TIMEOUT=64, DISCARD=1) talks to a behavioural
//   differentiator (y = x - x_prev) with a programmable response delay; dut_b
//   (TICK_DIV=8, TIMEOUT=4) talks to a differentiator that never answers.
//   Cycle i of each test is the i-th clock after the inputs are set; outputs are
//   sampled 1 time unit after the rising edge.
module tb_diff_sample_sequencer;
    logic        clk;
    logic        rst;
    logic        enable, clear_err, adc_valid;
    logic [15:0] adc_data;
    logic        enable_b, clear_err_b;

    logic        out_valid, busy, err_timeout, err_overrun;
    logic [15:0] out_data;
    logic [31:0] sample_count;
    logic        out_valid_b, busy_b, err_timeout_b, err_overrun_b;
    logic [15:0] out_data_b;
    logic [31:0] sample_count_b;

    int checks = 0;
    int errors = 0;

    diff_sample_sequencer_if #(.DATA_W(16)) axis_a ();
    diff_sample_sequencer_if #(.DATA_W(16)) axis_b ();

    diff_sample_sequencer #(.DATA_W(16), .TICK_DIV(8), .TIMEOUT(64), .DISCARD(1)) dut_a (
        .clk(clk), .rst(rst), .enable(enable), .clear_err(clear_err),
        .adc_valid(adc_valid), .adc_data(adc_data), .axis(axis_a),
        .out_valid(out_valid), .out_data(out_data), .busy(busy),
        .err_timeout(err_timeout), .err_overrun(err_overrun), .sample_count(sample_count)
    );

    diff_sample_sequencer #(.DATA_W(16), .TICK_DIV(8), .TIMEOUT(4), .DISCARD(1)) dut_b (
        .clk(clk), .rst(rst), .enable(enable_b), .clear_err(clear_err_b),
        .adc_valid(adc_valid), .adc_data(adc_data), .axis(axis_b),
        .out_valid(out_valid_b), .out_data(out_data_b), .busy(busy_b),
        .err_timeout(err_timeout_b), .err_overrun(err_overrun_b),
        .sample_count(sample_count_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Differentiator model for dut_a: a handshake seen mid-cycle H produces
    // m_axis_tvalid during cycle H+1+resp_delay.
    int          resp_delay = 0;
    int          cd = 0;
    logic        pend = 1'b0;
    logic [15:0] x_prev = '0;
    logic [15:0] res = '0;

    always @(negedge clk) begin
        if (rst) begin
            pend = 1'b0;
            x_prev = '0;
            axis_a.m_axis_tvalid = 1'b0;
            axis_a.m_axis_tdata = '0;
        end else begin
            axis_a.m_axis_tvalid = 1'b0;
            if (pend) begin
                if (cd == 0) begin
                    axis_a.m_axis_tvalid = 1'b1;
                    axis_a.m_axis_tdata = res;
                    pend = 1'b0;
                end else begin
                    cd = cd - 1;
                end
            end
            if (axis_a.s_axis_tvalid && axis_a.s_axis_tready) begin
                res = axis_a.s_axis_tdata - x_prev;
                x_prev = axis_a.s_axis_tdata;
                pend = 1'b1;
                cd = resp_delay;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        enable = 1'b0; clear_err = 1'b0; adc_valid = 1'b0; adc_data = '0;
        enable_b = 1'b0; clear_err_b = 1'b0;
        axis_a.s_axis_tready = 1'b1;
        axis_b.s_axis_tready = 1'b1;
        axis_b.m_axis_tvalid = 1'b0;
        axis_b.m_axis_tdata = '0;
        resp_delay = 0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        step();
        checks++; if (axis_a.s_axis_tvalid !== 1'b0) begin errors++;
            $display("FAIL reset_tvalid got %0h exp 0", axis_a.s_axis_tvalid); end
        checks++; if (axis_a.s_axis_tdata !== 16'h0) begin errors++;
            $display("FAIL reset_tdata got %0h exp 0", axis_a.s_axis_tdata); end
        checks++; if (out_valid !== 1'b0) begin errors++;
            $display("FAIL reset_out_valid got %0h exp 0", out_valid); end
        checks++; if (out_data !== 16'h0) begin errors++;
            $display("FAIL reset_out_data got %0h exp 0", out_data); end
        checks++; if (busy !== 1'b0) begin errors++;
            $display("FAIL reset_busy got %0h exp 0", busy); end
        checks++; if (err_timeout !== 1'b0) begin errors++;
            $display("FAIL reset_err_timeout got %0h exp 0", err_timeout); end
        checks++; if (err_overrun !== 1'b0) begin errors++;
            $display("FAIL reset_err_overrun got %0h exp 0", err_overrun); end
        checks++; if (sample_count !== 32'h0) begin errors++;
            $display("FAIL reset_sample_count got %0h exp 0", sample_count); end
        checks++; if (axis_b.s_axis_tvalid !== 1'b0 || busy_b !== 1'b0) begin errors++;
            $display("FAIL reset_b_idle got tvalid=%0h busy=%0h exp 0 0",
                     axis_b.s_axis_tvalid, busy_b); end
    endtask

    // Ramp 0,1,2,... one step per sample; tvalid at 9,17,25,33,41; first result
    // dropped, then out_valid at 19,27,35,43 carrying 1.
    task automatic test_ramp();
        logic        exp_tv, exp_ov;
        logic [15:0] k;
        do_reset();
        adc_valid = 1'b1; adc_data = 16'd0; enable = 1'b1;
        k = 16'd0;
        for (int i = 1; i <= 45; i++) begin
            step();
            exp_tv = (i >= 9) && (((i - 9) % 8) == 0);
            exp_ov = (i >= 19) && (((i - 19) % 8) == 0);
            checks++; if (axis_a.s_axis_tvalid !== exp_tv) begin errors++;
                $display("FAIL ramp_tvalid cyc %0d got %0h exp %0h", i,
                         axis_a.s_axis_tvalid, exp_tv); end
            checks++; if (out_valid !== exp_ov) begin errors++;
                $display("FAIL ramp_out_valid cyc %0d got %0h exp %0h", i, out_valid, exp_ov); end
            if (exp_tv) begin
                checks++; if (axis_a.s_axis_tdata !== k) begin errors++;
                    $display("FAIL ramp_tdata cyc %0d got %0h exp %0h", i,
                             axis_a.s_axis_tdata, k); end
                k = k + 16'd1;
                adc_data = k;
            end
            if (exp_ov) begin
                checks++; if (out_data !== 16'd1) begin errors++;
                    $display("FAIL ramp_out_data cyc %0d got %0h exp 1", i, out_data); end
                checks++; if (sample_count !== 32'((i - 19) / 8 + 1)) begin errors++;
                    $display("FAIL ramp_count cyc %0d got %0d exp %0d", i, sample_count,
                             (i - 19) / 8 + 1); end
            end
        end
        checks++; if (sample_count !== 32'd4) begin errors++;
            $display("FAIL ramp_final_count got %0d exp 4", sample_count); end
    endtask

    // tready low for cycles 9..11, handshake in 12; tdata frozen at 0x0010.
    task automatic test_backpressure();
        do_reset();
        axis_a.s_axis_tready = 1'b0;
        adc_valid = 1'b1; adc_data = 16'h0010; enable = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i >= 9 && i <= 12) begin
                checks++; if (axis_a.s_axis_tvalid !== 1'b1) begin errors++;
                    $display("FAIL bp_tvalid_hold cyc %0d got %0h exp 1", i,
                             axis_a.s_axis_tvalid); end
                checks++; if (axis_a.s_axis_tdata !== 16'h0010) begin errors++;
                    $display("FAIL bp_tdata_frozen cyc %0d got %0h exp 10", i,
                             axis_a.s_axis_tdata); end
            end
            if (i == 13) begin
                checks++; if (axis_a.s_axis_tvalid !== 1'b0 || busy !== 1'b1) begin errors++;
                    $display("FAIL bp_after_hs got tvalid=%0h busy=%0h exp 0 1",
                             axis_a.s_axis_tvalid, busy); end
            end
            if (i == 14) begin
                checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || sample_count !== 32'd0)
                begin errors++;
                    $display("FAIL bp_discard got busy=%0h ov=%0h cnt=%0d exp 0 0 0",
                             busy, out_valid, sample_count); end
            end
            if (i == 17) begin
                checks++; if (axis_a.s_axis_tvalid !== 1'b1 || axis_a.s_axis_tdata !== 16'h0020)
                begin errors++;
                    $display("FAIL bp_next_sample got tvalid=%0h tdata=%0h exp 1 20",
                             axis_a.s_axis_tvalid, axis_a.s_axis_tdata); end
            end
            if (i == 19) begin
                checks++; if (out_valid !== 1'b1 || out_data !== 16'h0010) begin errors++;
                    $display("FAIL bp_result got ov=%0h data=%0h exp 1 10", out_valid, out_data); end
            end
            if (i == 9)  adc_data = 16'h0020;
            if (i == 12) axis_a.s_axis_tready = 1'b1;
        end
    endtask

    // dut_b never gets a result: WAIT_RES 10..13 -> err at 14; second send at 17;
    // clear at 23; clear coinciding with the third timeout (cycle 29) loses.
    task automatic test_timeout();
        do_reset();
        enable_b = 1'b1;
        for (int i = 1; i <= 31; i++) begin
            step();
            if (i == 13) begin
                checks++; if (err_timeout_b !== 1'b0 || busy_b !== 1'b1) begin errors++;
                    $display("FAIL to_before got err=%0h busy=%0h exp 0 1", err_timeout_b, busy_b); end
            end
            if (i == 14) begin
                checks++; if (err_timeout_b !== 1'b1 || busy_b !== 1'b0) begin errors++;
                    $display("FAIL to_fire got err=%0h busy=%0h exp 1 0", err_timeout_b, busy_b); end
            end
            if (i == 17) begin
                checks++; if (axis_b.s_axis_tvalid !== 1'b1) begin errors++;
                    $display("FAIL to_resend got %0h exp 1", axis_b.s_axis_tvalid); end
            end
            if (i == 23) begin
                checks++; if (err_timeout_b !== 1'b1) begin errors++;
                    $display("FAIL to_sticky got %0h exp 1", err_timeout_b); end
            end
            if (i == 24 || i == 29 || i == 31) begin
                checks++; if (err_timeout_b !== 1'b0) begin errors++;
                    $display("FAIL to_cleared cyc %0d got %0h exp 0", i, err_timeout_b); end
            end
            if (i == 30) begin
                checks++; if (err_timeout_b !== 1'b1) begin errors++;
                    $display("FAIL to_set_wins got %0h exp 1", err_timeout_b); end
            end
            clear_err_b = (i == 23) || (i == 29) || (i == 30);
        end
        checks++; if (err_overrun_b !== 1'b0) begin errors++;
            $display("FAIL to_no_overrun got %0h exp 0", err_overrun_b); end
        enable_b = 1'b0;
    endtask

    // Result 10 cycles late: WAIT_RES 10..20, tick at 16 overruns and is dropped.
    task automatic test_overrun();
        do_reset();
        resp_delay = 10;
        adc_valid = 1'b1; adc_data = 16'd7; enable = 1'b1;
        for (int i = 1; i <= 25; i++) begin
            step();
            if (i >= 10 && i <= 24) begin
                checks++; if (axis_a.s_axis_tvalid !== 1'b0) begin errors++;
                    $display("FAIL ov_no_send cyc %0d got %0h exp 0", i, axis_a.s_axis_tvalid); end
            end
            if (i == 16) begin
                checks++; if (err_overrun !== 1'b0) begin errors++;
                    $display("FAIL ov_before got %0h exp 0", err_overrun); end
            end
            if (i == 17) begin
                checks++; if (err_overrun !== 1'b1) begin errors++;
                    $display("FAIL ov_set got %0h exp 1", err_overrun); end
            end
            if (i == 20) begin
                checks++; if (busy !== 1'b1) begin errors++;
                    $display("FAIL ov_busy got %0h exp 1", busy); end
            end
            if (i == 21) begin
                checks++; if (busy !== 1'b0) begin errors++;
                    $display("FAIL ov_done got %0h exp 0", busy); end
            end
            if (i == 25) begin
                checks++; if (axis_a.s_axis_tvalid !== 1'b1) begin errors++;
                    $display("FAIL ov_next_tick got %0h exp 1", axis_a.s_axis_tvalid); end
            end
        end
    endtask

    // Samples 5 then 12; enable drops at 19 during the second WAIT_RES (18..21):
    // result 7 forwarded at 22, then idle. Re-enable at 41: send at 50, discarded.
    task automatic test_enable_drop();
        do_reset();
        resp_delay = 3;
        adc_valid = 1'b1; adc_data = 16'd5; enable = 1'b1;
        for (int i = 1; i <= 60; i++) begin
            step();
            if (i == 22) begin
                checks++; if (out_valid !== 1'b1 || out_data !== 16'd7 || sample_count !== 32'd1)
                begin errors++;
                    $display("FAIL en_forward got ov=%0h data=%0h cnt=%0d exp 1 7 1",
                             out_valid, out_data, sample_count); end
                checks++; if (busy !== 1'b0) begin errors++;
                    $display("FAIL en_busy got %0h exp 0", busy); end
            end
            if (i >= 23 && i <= 49) begin
                checks++; if (axis_a.s_axis_tvalid !== 1'b0) begin errors++;
                    $display("FAIL en_idle cyc %0d got %0h exp 0", i, axis_a.s_axis_tvalid); end
            end
            if (i == 50) begin
                checks++; if (axis_a.s_axis_tvalid !== 1'b1 || axis_a.s_axis_tdata !== 16'd12)
                begin errors++;
                    $display("FAIL en_resend got tvalid=%0h tdata=%0h exp 1 c",
                             axis_a.s_axis_tvalid, axis_a.s_axis_tdata); end
            end
            if (i >= 51) begin
                checks++; if (out_valid !== 1'b0 || sample_count !== 32'd1) begin errors++;
                    $display("FAIL en_rediscard cyc %0d got ov=%0h cnt=%0d exp 0 1", i,
                             out_valid, sample_count); end
            end
            if (i == 9)  adc_data = 16'd12;
            if (i == 19) enable = 1'b0;
            if (i == 41) enable = 1'b1;
        end
    endtask

    // Forward one result (7), stall the third send in SEND until a tick overruns,
    // then reset while still in SEND.
    task automatic test_reset_in_send();
        do_reset();
        adc_valid = 1'b1; adc_data = 16'd3; enable = 1'b1;
        for (int i = 1; i <= 36; i++) begin
            step();
            if (i == 19) begin
                checks++; if (out_valid !== 1'b1 || out_data !== 16'd7) begin errors++;
                    $display("FAIL rs_result got ov=%0h data=%0h exp 1 7", out_valid, out_data); end
            end
            if (i == 34) begin
                checks++; if (axis_a.s_axis_tvalid !== 1'b1 || err_overrun !== 1'b1 ||
                              sample_count !== 32'd1) begin errors++;
                    $display("FAIL rs_pre got tvalid=%0h ovr=%0h cnt=%0d exp 1 1 1",
                             axis_a.s_axis_tvalid, err_overrun, sample_count); end
            end
            if (i == 35) begin
                checks++; if (axis_a.s_axis_tvalid !== 1'b0 || busy !== 1'b0) begin errors++;
                    $display("FAIL rs_idle got tvalid=%0h busy=%0h exp 0 0",
                             axis_a.s_axis_tvalid, busy); end
                checks++; if (sample_count !== 32'd0 || out_data !== 16'd0) begin errors++;
                    $display("FAIL rs_count got cnt=%0d data=%0h exp 0 0", sample_count, out_data); end
                checks++; if (err_overrun !== 1'b0 || err_timeout !== 1'b0) begin errors++;
                    $display("FAIL rs_errs got ovr=%0h to=%0h exp 0 0", err_overrun, err_timeout); end
            end
            if (i == 36) begin
                checks++; if (axis_a.s_axis_tvalid !== 1'b0 || busy !== 1'b0) begin errors++;
                    $display("FAIL rs_stays_idle got tvalid=%0h busy=%0h exp 0 0",
                             axis_a.s_axis_tvalid, busy); end
            end
            if (i == 9)  adc_data = 16'd10;
            if (i == 18) axis_a.s_axis_tready = 1'b0;
            if (i == 34) begin rst = 1'b1; enable = 1'b0; end
            if (i == 35) begin rst = 1'b0; axis_a.s_axis_tready = 1'b1; end
        end
    endtask

    initial begin
        rst = 1'b1;
        enable = 1'b0; clear_err = 1'b0; adc_valid = 1'b0; adc_data = '0;
        enable_b = 1'b0; clear_err_b = 1'b0;
        axis_a.s_axis_tready = 1'b1;
        axis_b.s_axis_tready = 1'b1;
        axis_b.m_axis_tvalid = 1'b0;
        axis_b.m_axis_tdata = '0;
        test_reset();
        test_ramp();
        test_backpressure();
        test_timeout();
        test_overrun();
        test_enable_drop();
        test_reset_in_send();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/diff_sample_sequencer.md
# diff_sample_sequencer

Sample-rate scheduler that sequences the FIR differentiator stage of the ECG processing chain. It paces the latest ADC sample into the differentiator's AXI-Stream slave at a fixed sample rate, one transaction in flight at a time. It waits for the matching result, discards the start-up transient, and forwards clean derivative samples downstream. It also flags lost or late transactions with sticky error bits.

## Interface
- DATA_W, 16, sample and derivative width (signed)
- TICK_DIV, 250000, clk cycles per sample period (50 MHz / 200 Hz); legal range ≥ 4
- TIMEOUT, 64, max cycles to wait for a differentiator result after the handshake; legal range ≥ 2
- DISCARD, 1, number of results dropped after each enable rise (x[-1] = 0 transient)

- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- enable  in  1  run/stop for sample scheduling
- clear_err  in  1  one-cycle pulse that clears the sticky error bits
- adc_valid  in  1  adc_data is valid this cycle
- adc_data  in  DATA_W  signed ADC sample
- s_axis_tvalid  out  1  to differentiator slave
- s_axis_tready  in  1  from differentiator slave
- s_axis_tdata  out  DATA_W  sample to differentiator
- m_axis_tvalid  in  1  differentiator result valid
- m_axis_tdata  in  DATA_W  differentiator result
- out_valid  out  1  one-cycle pulse, forwarded derivative valid
- out_data  out  DATA_W  forwarded derivative (registered)
- busy  out  1  high in SEND or WAIT_RES
- err_timeout  out  1  sticky: result not received within TIMEOUT
- err_overrun  out  1  sticky: tick arrived while a transaction was in flight
- sample_count  out  32  number of results forwarded on out_valid; wraps at 2^32

## Operation
- Holding register: captures adc_data on every cycle with adc_valid=1. It is 0 after reset. A stale value is reused if no new sample has arrived.
- Tick counter: counts 0..TICK_DIV-1 while enable=1, and tick=1 when the count is TICK_DIV-1. The counter is held at 0 while enable=0.
- FSM states: IDLE, WAIT_TICK, SEND, WAIT_RES.
  - IDLE: if enable=1, go to WAIT_TICK. The discard counter is loaded with DISCARD on this transition.
  - WAIT_TICK: if enable=0, go to IDLE. On tick, load s_axis_tdata from the holding register and go to SEND.
  - SEND: s_axis_tvalid=1. s_axis_tdata is frozen; adc updates do not alter it. On s_axis_tready=1, go to WAIT_RES and clear the timeout counter.
  - WAIT_RES: on m_axis_tvalid=1, one of two actions applies, then the FSM goes to WAIT_TICK:
    - if the discard counter is nonzero, decrement it and forward nothing;
    - otherwise register m_axis_tdata into out_data, pulse out_valid and increment sample_count.
  - WAIT_RES timeout: after TIMEOUT cycles with no m_axis_tvalid, set err_timeout, forward nothing and go to WAIT_TICK.
- enable=0 is acted on only in WAIT_TICK. SEND and WAIT_RES always run to completion (handshake + result or timeout).
- A tick while in SEND or WAIT_RES sets err_overrun. The tick is dropped and is not queued.
- m_axis_tvalid outside WAIT_RES is ignored.
- A DISCARD result still counts as the completion of its transaction.
- If clear_err and an error set occur in the same cycle, the set wins.
- Arithmetic: out_data is a pass-through with no width change. sample_count increments modulo 2^32.

## Timing
- Reset values: s_axis_tvalid=0, s_axis_tdata=0, out_valid=0, out_data=0, busy=0, err_timeout=0, err_overrun=0, sample_count=0. FSM is in IDLE, tick counter is 0.
- With enable high from cycle E, the first tick comes at cycle E+1+TICK_DIV-1 and s_axis_tvalid rises the next cycle. Later ticks are spaced exactly TICK_DIV cycles apart.
- s_axis_tvalid falls in the cycle after the one where tvalid & tready are both 1. It never drops before that handshake.
- out_valid is asserted exactly 1 cycle after the accepted m_axis_tvalid, lasts one cycle, and is aligned with out_data and the updated sample_count.
- Timeout fires when the WAIT_RES cycle count reaches TIMEOUT. err_timeout is visible the following cycle.
- rst during any state takes effect at the next clk edge: all outputs return to reset values and any in-flight transaction is abandoned.

## Test plan
- TICK_DIV=8, DISCARD=1, tready=1, ideal 1-cycle differentiator model, ADC ramp 0,1,2,…: the first result is dropped, then out_data=1 per sample, sample_count increments, and the tvalid pulses are exactly 8 cycles apart.
- Hold s_axis_tready=0 for 3 cycles after tvalid rises, changing adc_data (0x0010→0x0020) during that hold: tvalid stays high, tdata stays 0x0010, and the transaction completes after tready=1.
- Model never returns m_axis_tvalid, TIMEOUT=4: err_timeout=1 after 4 WAIT_RES cycles, FSM back in WAIT_TICK, and the next tick sends again. Then pulse clear_err → err_timeout=0.
- TICK_DIV=8 with the model result delayed 10 cycles: err_overrun=1, the overlapping tick is dropped, and no second tvalid occurs while busy=1.
- Deassert enable mid-WAIT_RES: the result is still forwarded, then the FSM goes to IDLE and tvalid stays 0. Re-enable: the first result is discarded again.
- Assert rst while in SEND: next cycle tvalid=0, busy=0, sample_count=0, errors cleared.
